// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned rate_counter_bits(input int unsigned baud_divider);
    return (baud_divider > 1) ? $clog2(baud_divider) : 1;
  endfunction

  function automatic int unsigned bit_counter_bits(input int unsigned number_of_bits);
    return $clog2(number_of_bits + 1);
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop CDC stage for a single asynchronous level.
module synchronizer #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stage <= {STAGES{RESET_VALUE}};
    else       stage <= (stage << 1) | STAGES'(d);
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation, mid-bit sampling, stop check, single-entry output register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BITS = 8,
  parameter int unsigned BAUD_DIVIDER   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic [NUMBER_OF_BITS-1:0] data_bits,
  output logic                      framing_error,
  output logic                      overrun
);

  localparam int unsigned RATE_COUNTER_BITS = rate_counter_bits(BAUD_DIVIDER);
  localparam int unsigned BIT_COUNTER_BITS  = bit_counter_bits(NUMBER_OF_BITS);
  localparam logic [RATE_COUNTER_BITS-1:0] HALF_BIT = RATE_COUNTER_BITS'(BAUD_DIVIDER / 2 - 1);
  localparam logic [RATE_COUNTER_BITS-1:0] FULL_BIT = RATE_COUNTER_BITS'(BAUD_DIVIDER - 1);
  localparam logic [BIT_COUNTER_BITS-1:0]  ALL_BITS = BIT_COUNTER_BITS'(NUMBER_OF_BITS);
  localparam logic [BIT_COUNTER_BITS-1:0]  LAST_BIT = BIT_COUNTER_BITS'(1);

  uart_rx_state_t state, state_next;

  logic                         rx_s;
  logic [SYNC_STAGES-1:0]       settle;
  logic                         settled;
  logic [RATE_COUNTER_BITS-1:0] rate_counter;
  logic [BIT_COUNTER_BITS-1:0]  bit_counter;
  logic [NUMBER_OF_BITS-1:0]    shift, shift_next;
  logic                         tick;
  logic                         load_start, load_data, shift_bit, commit, stop_bad;
  logic                         accept, commit_ok;

  synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // The synchroniser's reset-time 1s are not line samples; WAIT_IDLE ignores
  // rx_s until they have been flushed so a line held low never starts a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) settle <= '0;
    else       settle <= (settle << 1) | SYNC_STAGES'(1'b1);
  end
  assign settled = settle[SYNC_STAGES-1];

  assign tick = (rate_counter == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (rx_s && settled) state_next = IDLE;
      IDLE:      if (!rx_s) state_next = START;
      START:     if (tick) state_next = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_counter == LAST_BIT) state_next = STOP;
      STOP:      if (tick) state_next = rx_s ? IDLE : WAIT_IDLE;
      default:   state_next = WAIT_IDLE;
    endcase
  end

  always_comb begin
    load_start = 1'b0;
    load_data  = 1'b0;
    shift_bit  = 1'b0;
    commit     = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE:  load_start = !rx_s;
      START: load_data  = tick && !rx_s;
      DATA:  shift_bit  = tick;
      STOP: begin
        commit   = tick && rx_s;
        stop_bad = tick && !rx_s;
      end
      default: ;
    endcase
  end

  assign accept    = data_valid && data_ready;
  assign commit_ok = commit && (!data_valid || data_ready);

  always_comb begin
    shift_next                   = shift >> 1;
    shift_next[NUMBER_OF_BITS-1] = rx_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rate_counter <= '0;
      bit_counter  <= '0;
      shift        <= '0;
    end else begin
      if (load_start)                rate_counter <= HALF_BIT;
      else if (load_data || shift_bit) rate_counter <= FULL_BIT;
      else if (!tick)                rate_counter <= rate_counter - RATE_COUNTER_BITS'(1);

      if (load_data)      bit_counter <= ALL_BITS;
      else if (shift_bit) bit_counter <= bit_counter - LAST_BIT;

      if (shift_bit) shift <= shift_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_valid    <= 1'b0;
      data_bits     <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= stop_bad;
      overrun       <= commit && !commit_ok;
      if (commit_ok) begin
        data_valid <= 1'b1;
        data_bits  <= shift;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
